// File: rtl/decoder_2x4_seq.sv
// Buffered 2-to-4 one-hot decoder: codes queue in a small FIFO and a hold-timer FSM
// drives each decoded word for HOLD_CYCLES cycles, back-to-back when codes are waiting.
module decoder_2x4_seq #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [1:0]                    in_code,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [3:0]                    out,
  output logic                          out_valid,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(HOLD_CYCLES - 1);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StIdle, StDrive} state_e;

  state_e          state_q;
  logic [1:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      out_q;
  logic            out_valid_q, done_q;
  logic            push, pop;
  logic [3:0]      head_onehot;

  always_comb begin
    push        = in_valid && in_ready && !flush;
    // A pop happens from IDLE, or from DRIVE in its last cycle; cnt is always 0 in IDLE.
    pop         = !flush && (level_q != '0) && ((state_q == StIdle) || (cnt_q == '0));
    level_d     = level_q + LvlW'(push) - LvlW'(pop);
    head_onehot = 4'b0001 << mem_q[rptr_q];
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      level_q <= level_d;

      if (pop) begin
        state_q     <= StDrive;
        out_q       <= head_onehot;
        out_valid_q <= 1'b1;
        cnt_q       <= CntLoad;
        done_q      <= (CntLoad == '0);
      end else if (state_q == StDrive) begin
        if (cnt_q != '0) begin
          cnt_q  <= cnt_q - CntW'(1);
          done_q <= (cnt_q == CntW'(1));
        end else begin
          state_q     <= StIdle;
          out_q       <= '0;
          out_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = (level_q != LvlFull);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign level     = level_q;

endmodule

// File: tb/tb_decoder_2x4_seq.sv
// Directed bench for decoder_2x4_seq: a HOLD_CYCLES=4 instance for the main scenarios
// and a HOLD_CYCLES=1 instance for the single-cycle hold case.
module tb_decoder_2x4_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       flush, in_valid, in_ready, out_valid, done;
  logic [1:0] in_code;
  logic [3:0] out_w;
  logic [2:0] level;

  logic       u1_flush, u1_valid, u1_ready, u1_out_valid, u1_done;
  logic [1:0] u1_code;
  logic [3:0] u1_out;
  logic [2:0] u1_level;

  int checks = 0;
  int failures = 0;

  decoder_2x4_seq #(.HOLD_CYCLES(4), .FIFO_DEPTH(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_code   (in_code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out_w),
    .out_valid (out_valid),
    .done      (done),
    .level     (level)
  );

  decoder_2x4_seq #(.HOLD_CYCLES(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (u1_flush),
    .in_code   (u1_code),
    .in_valid  (u1_valid),
    .in_ready  (u1_ready),
    .out       (u1_out),
    .out_valid (u1_out_valid),
    .done      (u1_done),
    .level     (u1_level)
  );

  // Hand-computed per-cycle tables, element i in nibble i (or 2-bit field i for codes).
  logic [19:0]  s_out_v  = 20'h04444;
  logic [4:0]   s_done_v = 5'b01000;
  logic [13:0]  b_code_v = 14'h09E4;
  logic [119:0] b_out_v  = 120'h0_1111_4444_2222_8888_4444_2222_1111_0;
  logic [119:0] b_lvl_v  = 120'h0_0000_1111_2222_3333_4443_4443_4321_1;
  logic [29:0]  b_done_v = 30'h1111_1110;
  logic [17:0]  g_v_v    = 18'h00027;
  logic [35:0]  g_code_v = 36'h0_0000_0813;
  logic [71:0]  g_out_v  = 72'h0_4444_2222_1111_8888_0;
  logic [71:0]  g_lvl_v  = 72'h00_0001_1112_2222_2211;
  logic [17:0]  g_done_v = 18'h11110;
  logic [14:0]  f_v_v    = 15'h009F;
  logic [14:0]  f_fl_v   = 15'h0080;
  logic [29:0]  f_code_v = 30'h0000_024D;
  logic [59:0]  f_out_v  = 60'h0000_0000_8822_220;
  logic [59:0]  f_lvl_v  = 60'h0000_0000_3343_211;
  logic [14:0]  f_done_v = 15'h0010;
  logic [4:0]   p_v_v    = 5'b00111;
  logic [9:0]   p_code_v = 10'h033;
  logic [19:0]  p_out_v  = 20'h08180;
  logic [19:0]  p_lvl_v  = 20'h00111;
  logic [4:0]   p_done_v = 5'b01110;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, got, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int idx, input logic [3:0] eo,
                          input logic [2:0] el, input logic ed);
    chk({tag, ".out"},       idx, 8'(out_w),     8'(eo));
    chk({tag, ".out_valid"}, idx, 8'(out_valid), 8'(eo != 4'h0));
    chk({tag, ".level"},     idx, 8'(level),     8'(el));
    chk({tag, ".done"},      idx, 8'(done),      8'(ed));
    chk({tag, ".in_ready"},  idx, 8'(in_ready),  8'(el != 3'd4));
  endtask

  task automatic chk_u1(input string tag, input int idx, input logic [3:0] eo,
                        input logic [2:0] el, input logic ed);
    chk({tag, ".out"},       idx, 8'(u1_out),       8'(eo));
    chk({tag, ".out_valid"}, idx, 8'(u1_out_valid), 8'(eo != 4'h0));
    chk({tag, ".level"},     idx, 8'(u1_level),     8'(el));
    chk({tag, ".done"},      idx, 8'(u1_done),      8'(ed));
    chk({tag, ".in_ready"},  idx, 8'(u1_ready),     8'(el != 3'd4));
  endtask

  initial begin
    int  k;
    logic acc;
    flush = 1'b0; in_valid = 1'b0; in_code = 2'b00;
    u1_flush = 1'b0; u1_valid = 1'b0; u1_code = 2'b00;

    // Reset state, held and just after release
    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 0, 4'h0, 3'd0, 1'b0);
    chk_u1("reset1", 0, 4'h0, 3'd0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_main("reset", 1, 4'h0, 3'd0, 1'b0);

    // Single code 10 into an idle block
    in_valid = 1'b1; in_code = 2'b10;
    tick();
    in_valid = 1'b0;
    chk_main("single", 0, 4'h0, 3'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_main("single", i + 1, s_out_v[i*4 +: 4], 3'd0, s_done_v[i]);
    end

    // Burst with back-pressure; upstream holds each code until accepted
    k = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid = (k < 7);
      in_code  = (k < 7) ? b_code_v[k*2 +: 2] : 2'b00;
      acc      = in_valid && in_ready;
      tick();
      if (acc) k++;
      chk_main("burst", c, b_out_v[c*4 +: 4], b_lvl_v[c*4 +: 3], b_done_v[c]);
    end
    in_valid = 1'b0;
    chk("burst.accepted", 0, 8'(k), 8'd7);

    // Push coinciding with a pop at level 2
    for (int c = 0; c < 18; c++) begin
      in_valid = g_v_v[c];
      in_code  = g_code_v[c*2 +: 2];
      tick();
      chk_main("pushpop", c, g_out_v[c*4 +: 4], g_lvl_v[c*4 +: 3], g_done_v[c]);
    end
    in_valid = 1'b0;

    // Flush during the 2nd cycle of 1000 with 3 queued and a concurrent push
    for (int c = 0; c < 15; c++) begin
      in_valid = f_v_v[c];
      flush    = f_fl_v[c];
      in_code  = f_code_v[c*2 +: 2];
      tick();
      chk_main("flush", c, f_out_v[c*4 +: 4], f_lvl_v[c*4 +: 3], f_done_v[c]);
    end
    in_valid = 1'b0; flush = 1'b0;

    // HOLD_CYCLES = 1 stream 11, 00, 11
    for (int c = 0; c < 5; c++) begin
      u1_valid = p_v_v[c];
      u1_code  = p_code_v[c*2 +: 2];
      tick();
      chk_u1("hold1", c, p_out_v[c*4 +: 4], p_lvl_v[c*4 +: 3], p_done_v[c]);
    end
    u1_valid = 1'b0;

    // Asynchronous reset in the middle of a hold window
    in_valid = 1'b1; in_code = 2'b01;
    tick();
    in_valid = 1'b0;
    tick();
    chk("prerst.out", 0, 8'(out_w), 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk_main("async_rst", 0, 4'h0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_main("post_rst", 0, 4'h0, 3'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_2x4_seq.md
# decoder_2x4_seq

Registered, buffered 2-to-4 one-hot decoder: the receive-side counterpart of our 4-to-2 encoder. Upstream pushes 2-bit codes through a valid/ready handshake into a 4-entry FIFO. A hold-timer FSM pops one code at a time and drives the matching one-hot line for a fixed number of cycles. It sits between the code-generating logic and the one-hot select/strobe lines it recreates.

## Interface
- `HOLD_CYCLES`, default 4: cycles each one-hot word is driven. Legal range 1..255.
- `FIFO_DEPTH`, default 4: code buffer entries. Power of two, ≥2.
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `flush` input 1: synchronous clear of the FIFO and FSM. It has priority over every other input.
- `in_code` input 2: code to decode.
- `in_valid` input 1: `in_code` is valid.
- `in_ready` output 1: FIFO can accept. Defined as `!full`.
- `out` output 4: one-hot decoded word. All zeros when idle.
- `out_valid` output 1: high while `out` is being driven.
- `done` output 1: one-cycle pulse in the final cycle of each code's hold window.
- `level` output $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Decode map:**
  - 00 → 0001
  - 01 → 0010
  - 10 → 0100
  - 11 → 1000
- There are no invalid codes, so `out` is never X.
- **Push:** occurs when `in_valid && in_ready`.
  - Codes are stored in order, using wrap-around read/write pointers of width $clog2(FIFO_DEPTH).
- **Pop:** occurs only when the FSM loads a new code.
- **Simultaneous push and pop:** `level` is unchanged, and both pointers advance.
- **Full FIFO:**
  - `in_ready` = 0, even if a pop occurs in the same cycle. `in_ready` has no combinational path from the pop.
  - `in_valid` with `in_ready` = 0 is ignored. Upstream holds `in_code` until accepted.
- **FSM states:**
  - IDLE: `out` = 0, `out_valid` = 0.
    - If `level` ≠ 0: pop the head, register its one-hot into `out`, load `cnt` = `HOLD_CYCLES`−1, go to DRIVE.
  - DRIVE: `out_valid` = 1 and `out` is held.
    - If `cnt` ≠ 0: decrement `cnt`.
    - If `cnt` = 0: assert `done`.
      - If `level` ≠ 0: pop the next code back-to-back. Load the new `out` and `cnt`, and stay in DRIVE with no gap cycle.
      - Else: go to IDLE and clear `out`.
- **Flush:** on the next edge, pointers, `level`, and `cnt` become 0; state becomes IDLE; `out`, `out_valid`, and `done` become 0.
  - A push in the same cycle as `flush` is discarded.
- **Reset (`rst_n` low):** takes effect immediately, including mid-hold. It forces the same values as `flush`.
  - Reset values: `out` = 0000, `out_valid` = 0, `done` = 0, `level` = 0, `in_ready` = 1.
- **Widths:** `cnt` is $clog2(HOLD_CYCLES) bits, with a minimum of 1. With `HOLD_CYCLES` = 1, DRIVE lasts one cycle per code and `done` is high in that same cycle.

## Timing
- **Latency:** a code pushed at edge N into an empty FIFO with the FSM in IDLE:
  - is popped at edge N+1;
  - `out` and `out_valid` are visible after edge N+1;
  - the word stays held for exactly `HOLD_CYCLES` cycles.
- **Throughput:** one code per `HOLD_CYCLES` cycles when the FIFO is non-empty. Output words are contiguous.
- **Return to IDLE:** `done` is asserted in the last DRIVE cycle. If nothing is queued, `out` = 0 after the following edge.
- **Registered outputs:** `in_ready`, `out`, `out_valid`, `done`, and `level` are all registered or derived only from registered state. No input-to-output combinational paths exist.

## Test plan
- **Reset check:** pulse `rst_n` low asynchronously mid-cycle → outputs immediately go to `out` = 0000, `out_valid` = 0, `in_ready` = 1, `level` = 0.
- **Single code:** push 10 into an idle block (`HOLD_CYCLES` = 4) → `out` = 0100 for exactly 4 cycles starting 1 edge after the push, `done` high in the 4th cycle, then `out` = 0000.
- **Burst with back-pressure:** push 00, 01, 10, 11, 01 on consecutive cycles → `in_ready` drops when `level` reaches 4. The 5th code is accepted only after the first pop. Output sequence is 0001, 0010, 0100, 1000, 0010, each held 4 cycles with no gaps.
- **Simultaneous push/pop:** hold `level` = 2 and push in the same cycle as a pop → `level` stays 2 and order is preserved.
- **Flush mid-hold:** assert `flush` during the 2nd cycle of 1000 with 3 codes queued, plus a concurrent push → next cycle `out` = 0000, `level` = 0, state IDLE. No queued code, and not the concurrent push, ever appears on `out`.
- **HOLD_CYCLES = 1:** stream 11, 00, 11 → `out` = 1000, 0001, 1000 on 3 consecutive cycles, with `done` high on all 3.
